forward_hazard_unit: RTL and testbench
======================================

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 The block SHALL have parameter RA_W, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-003 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 id_rs_i  input  RA_W  rs of the instruction in ID.
REQ-006 id_rt_i  input  RA_W  rt of the instruction in ID.
REQ-007 id_rt_used_i  input  1  ID instruction reads rt; when 0, rt SHALL be ignored for hazards and forwarding.
REQ-008 id_rd_i  input  RA_W  destination of the ID instruction.
REQ-009 id_regwrite_i  input  1  ID instruction writes the register file.
REQ-010 id_memread_i  input  1  ID instruction is a load.
REQ-011 flush_i  input  1  discard the ID instruction (taken branch).
REQ-012 fwd_a_sel_o  output  2  EX operand-A select for the downstream 4:1 operand mux.
REQ-013 fwd_b_sel_o  output  2  EX operand-B select for the downstream 4:1 operand mux.
REQ-014 stall_o  output  1  hold PC and IF/ID, and inject a bubble into EX.
REQ-015 stall_cnt_o  output  CNT_W  count of stall cycles since reset.

Function
REQ-016 The block SHALL keep three destination trackers: EX, MEM and WB. Each tracker SHALL hold rd, regwrite and memread.
REQ-017 Each cycle, MEM SHALL take EX and WB SHALL take MEM, unconditionally.
REQ-018 EX SHALL take the ID fields when stall_o=0 and flush_i=0; otherwise EX SHALL take a bubble (regwrite=0, memread=0, rd=0).
REQ-019 A tracker SHALL match a source register s only when regwrite=1, rd!=0 and rd==s.
REQ-020 stall_o SHALL be combinational and SHALL be 1 when the EX tracker has memread=1 and matches id_rs_i, or matches id_rt_i with id_rt_used_i=1.
REQ-021 flush_i=1 SHALL force stall_o=0 in the same cycle.
REQ-022 The next value of the A select SHALL be computed from id_rs_i with priority: EX-tracker match gives 1 (EX/MEM result); else MEM-tracker match gives 2 (MEM/WB data); else WB-tracker match gives 3 (retired-write bypass); else 0 (register file).
REQ-023 The next value of the B select SHALL use the same priority with id_rt_i; when id_rt_used_i=0 it SHALL be 0.
REQ-024 fwd_a_sel_o and fwd_b_sel_o SHALL be registered, loaded on the same edge that loads EX. They are therefore valid while the instruction occupies EX, with latency 1 cycle from ID.
REQ-025 When a bubble is loaded into EX, both selects SHALL load 0.
REQ-026 stall_cnt_o SHALL increment by 1 each cycle stall_o=1 and SHALL saturate at all-ones without wrapping.
REQ-027 A load-use hazard SHALL stall exactly 1 cycle; the following cycle the consumer SHALL enter EX with select 2.

Reset
REQ-028 rst_i=1 SHALL immediately clear all trackers, set fwd_a_sel_o=0, fwd_b_sel_o=0 and stall_cnt_o=0, and force stall_o to 0, without waiting for a clock edge.
REQ-029 Reset asserted mid-stall SHALL abort the stall; the first cycle after release SHALL treat all in-flight instructions as bubbles.

Configuration
REQ-030 With macro FWD_WB_BYPASS_EN defined, select value 3 SHALL be produced as in REQ-022.
REQ-031 Without FWD_WB_BYPASS_EN, a WB-tracker match SHALL give 0; selects SHALL never equal 3, relying on register-file write-before-read.

Verification
REQ-032 Back-to-back dependence: ID add rd=5 regwrite=1, then ID sub rs=5 -> fwd_a_sel_o=1 while sub is in EX, stall_o=0 throughout.
REQ-033 Load-use: ID lw rd=8 memread=1, then ID add rt=8 rt_used=1 -> stall_o=1 for one cycle, stall_cnt_o=1, then fwd_b_sel_o=2.
REQ-034 Distance-3 dependence with FWD_WB_BYPASS_EN: writer rd=3, two unrelated instructions, then reader rs=3 -> fwd_a_sel_o=3; without the macro -> fwd_a_sel_o=0.
REQ-035 Register zero: writer rd=0 regwrite=1, then reader rs=0 -> fwd_a_sel_o=0 and stall_o=0, including when the writer is a load.
REQ-036 Flush during load-use: flush_i=1 in the hazard cycle -> stall_o=0, next cycle both selects=0, stall_cnt_o unchanged.
REQ-037 Priority and saturation: writers rd=4 in both EX and MEM -> select 1. With CNT_W=2, 5 forced stall cycles -> stall_cnt_o stays 3.

Source files
------------

// File: rtl/forward_hazard_unit.sv
// Operand-forwarding selects and load-use stall detection for a 5-stage pipeline.
// Define FWD_WB_BYPASS_EN to enable the retired-write bypass (select value 3).
module forward_hazard_unit #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [RA_W-1:0]  id_rs_i,
    input  logic [RA_W-1:0]  id_rt_i,
    input  logic             id_rt_used_i,
    input  logic [RA_W-1:0]  id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             flush_i,
    output logic [1:0]       fwd_a_sel_o,
    output logic [1:0]       fwd_b_sel_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

`ifdef FWD_WB_BYPASS_EN
    localparam bit WB_BYPASS = 1'b1;
`else
    localparam bit WB_BYPASS = 1'b0;
`endif

    localparam int EX  = 0;
    localparam int MEM = 1;
    localparam int WB  = 2;

    // Destination trackers, index 0 = EX, 1 = MEM, 2 = WB.
    logic [RA_W-1:0]  trk_rd_reg [3];
    logic             trk_rw_reg [3];
    logic             trk_mr_reg [3];

    logic             match_rs [3];
    logic             match_rt [3];
    logic             stall;
    logic             ex_load;
    logic [1:0]       fwd_a_sel_reg;
    logic [1:0]       fwd_b_sel_reg;
    logic [1:0]       fwd_a_sel_next;
    logic [1:0]       fwd_b_sel_next;
    logic [CNT_W-1:0] stall_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_match
            assign match_rs[gi] = trk_rw_reg[gi] && (trk_rd_reg[gi] != '0)
                                  && (trk_rd_reg[gi] == id_rs_i);
            assign match_rt[gi] = id_rt_used_i && trk_rw_reg[gi] && (trk_rd_reg[gi] != '0)
                                  && (trk_rd_reg[gi] == id_rt_i);
        end
    endgenerate

    // Load-use: the loaded value is not available until the load reaches MEM/WB.
    assign stall   = !rst_i && !flush_i && trk_mr_reg[EX] && (match_rs[EX] || match_rt[EX]);
    assign ex_load = !stall && !flush_i;

    always_comb begin
        fwd_a_sel_next = 2'd0;
        fwd_b_sel_next = 2'd0;
        if (match_rs[EX])
            fwd_a_sel_next = 2'd1;
        else if (match_rs[MEM])
            fwd_a_sel_next = 2'd2;
        else if (WB_BYPASS && match_rs[WB])
            fwd_a_sel_next = 2'd3;
        if (match_rt[EX])
            fwd_b_sel_next = 2'd1;
        else if (match_rt[MEM])
            fwd_b_sel_next = 2'd2;
        else if (WB_BYPASS && match_rt[WB])
            fwd_b_sel_next = 2'd3;
        if (!ex_load) begin
            fwd_a_sel_next = 2'd0;
            fwd_b_sel_next = 2'd0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 3; i++) begin
                trk_rd_reg[i] <= '0;
                trk_rw_reg[i] <= 1'b0;
                trk_mr_reg[i] <= 1'b0;
            end
        end else begin
            for (int i = 2; i > 0; i--) begin
                trk_rd_reg[i] <= trk_rd_reg[i-1];
                trk_rw_reg[i] <= trk_rw_reg[i-1];
                trk_mr_reg[i] <= trk_mr_reg[i-1];
            end
            if (ex_load) begin
                trk_rd_reg[EX] <= id_rd_i;
                trk_rw_reg[EX] <= id_regwrite_i;
                trk_mr_reg[EX] <= id_memread_i;
            end else begin
                trk_rd_reg[EX] <= '0;
                trk_rw_reg[EX] <= 1'b0;
                trk_mr_reg[EX] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fwd_a_sel_reg <= 2'd0;
            fwd_b_sel_reg <= 2'd0;
        end else begin
            fwd_a_sel_reg <= fwd_a_sel_next;
            fwd_b_sel_reg <= fwd_b_sel_next;
        end
    end

    // Saturating so a long-running counter never wraps back to a small value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            stall_cnt_reg <= '0;
        else if (stall && (stall_cnt_reg != {CNT_W{1'b1}}))
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end

    assign stall_o     = stall;
    assign fwd_a_sel_o = fwd_a_sel_reg;
    assign fwd_b_sel_o = fwd_b_sel_reg;
    assign stall_cnt_o = stall_cnt_reg;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Scoreboard bench for forward_hazard_unit: directed instruction sequences push expectations,
// a negedge monitor pops and compares them. A second instance with CNT_W=2 covers saturation.
module tb_forward_hazard_unit;
    localparam int RA_W = 5;
`ifdef FWD_WB_BYPASS_EN
    localparam int WBV = 3;
`else
    localparam int WBV = 0;
`endif

    logic            clk;
    logic            rst_i;
    logic [RA_W-1:0] id_rs_i, id_rt_i, id_rd_i;
    logic            id_rt_used_i, id_regwrite_i, id_memread_i, flush_i;
    logic [1:0]      fwd_a_sel_o, fwd_b_sel_o, fwd_a_sel2, fwd_b_sel2;
    logic            stall_o, stall2;
    logic [15:0]     stall_cnt_o;
    logic [1:0]      stall_cnt2;

    forward_hazard_unit #(.RA_W(RA_W), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_rt_used_i(id_rt_used_i), .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
        .id_memread_i(id_memread_i), .flush_i(flush_i), .fwd_a_sel_o(fwd_a_sel_o),
        .fwd_b_sel_o(fwd_b_sel_o), .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
    );

    forward_hazard_unit #(.RA_W(RA_W), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_rt_used_i(id_rt_used_i), .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
        .id_memread_i(id_memread_i), .flush_i(flush_i), .fwd_a_sel_o(fwd_a_sel2),
        .fwd_b_sel_o(fwd_b_sel2), .stall_o(stall2), .stall_cnt_o(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        int    kind;
        int    val;
        string name;
    } exp_t;

    exp_t  sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    drain_expired = 1'b0;
    string kind_name [5] = '{"stall", "sel_a", "sel_b", "cnt", "cnt_sat"};

    // Monitor: compare every expectation due at or before this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                int act;
                case (sb[i].kind)
                    0:       act = int'(stall_o);
                    1:       act = int'(fwd_a_sel_o);
                    2:       act = int'(fwd_b_sel_o);
                    3:       act = int'(stall_cnt_o);
                    default: act = int'(stall_cnt2);
                endcase
                n_tests++;
                if (act != sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s.%s cyc=%0d: got %0d, expected %0d",
                             sb[i].name, kind_name[sb[i].kind], cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
        if (drain_expired && sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
            sb.delete();
        end
    end

    task automatic push(input string name, input int d, input int kind, input int val);
        exp_t e;
        e.cyc  = cyc + d;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    // Expect stall/sel_a/sel_b/cnt d cycles from now; negative values are skipped.
    task automatic ex(input string name, input int d, input int s, input int a, input int b, input int c);
        if (s >= 0) push(name, d, 0, s);
        if (a >= 0) push(name, d, 1, a);
        if (b >= 0) push(name, d, 2, b);
        if (c >= 0) push(name, d, 3, c);
    endtask

    task automatic drive(input int rs, input int rt, input int used, input int rd,
                         input int rw, input int mr, input int fl);
        id_rs_i       = rs[RA_W-1:0];
        id_rt_i       = rt[RA_W-1:0];
        id_rt_used_i  = used[0];
        id_rd_i       = rd[RA_W-1:0];
        id_regwrite_i = rw[0];
        id_memread_i  = mr[0];
        flush_i       = fl[0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            step();
        end
    endtask

    initial begin
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        ex("reset", 0, 0, 0, 0, 0);
        push("reset", 0, 4, 0);
        step();
        rst_i = 1'b0;
        nops(3);

        // Back-to-back dependence: EX/MEM forward on operand A.
        drive(1, 2, 1, 5, 1, 0, 0);  ex("b2b_add", 0, 0, -1, -1, -1); step();
        drive(5, 6, 1, 7, 1, 0, 0);  ex("b2b_sub", 0, 0, -1, -1, -1); ex("b2b_sub", 1, -1, 1, 0, -1); step();
        nops(3);

        // Load-use: one stall cycle, bubble, then MEM/WB forward on B.
        drive(9, 0, 0, 8, 1, 1, 0);  ex("lu_lw", 0, 0, -1, -1, -1); step();
        drive(10, 8, 1, 11, 1, 0, 0); ex("lu_stall", 0, 1, -1, -1, -1); ex("lu_bubble", 1, -1, 0, 0, 1); step();
        ex("lu_release", 0, 0, -1, -1, -1); ex("lu_fwd", 1, -1, 0, 2, 1); step();
        nops(3);

        // Distance-3 dependence; rt matches EX but is not used.
        drive(0, 0, 0, 3, 1, 0, 0);  step();
        drive(0, 0, 0, 12, 1, 0, 0); step();
        drive(0, 0, 0, 13, 1, 0, 0); step();
        drive(3, 13, 0, 14, 1, 0, 0); ex("dist3", 0, 0, -1, -1, -1); ex("dist3", 1, -1, WBV, 0, -1); step();
        nops(3);

        // Register zero, writer is a load and then an ALU op.
        drive(0, 0, 0, 0, 1, 1, 0);  step();
        drive(0, 0, 1, 0, 0, 0, 0);  ex("r0_load", 0, 0, -1, -1, -1); ex("r0_load", 1, -1, 0, 0, -1); step();
        drive(0, 0, 0, 0, 1, 0, 0);  step();
        drive(0, 0, 1, 0, 0, 0, 0);  ex("r0_alu", 1, -1, 0, 0, -1); step();
        nops(3);

        // Flush in the hazard cycle.
        drive(0, 0, 0, 8, 1, 1, 0);  step();
        drive(8, 0, 0, 15, 1, 0, 1); ex("flush", 0, 0, -1, -1, -1); ex("flush", 1, -1, 0, 0, 1); step();
        nops(3);

        // Load in EX matching an unused rt must not stall.
        drive(0, 0, 0, 20, 1, 1, 0); step();
        drive(0, 20, 0, 0, 0, 0, 0); ex("rt_unused", 0, 0, -1, -1, -1); ex("rt_unused", 1, -1, -1, 0, -1); step();
        nops(3);

        // Priority: EX over MEM, then MEM over WB.
        drive(0, 0, 0, 4, 1, 0, 0);  step();
        drive(0, 0, 0, 4, 1, 0, 0);  step();
        drive(4, 4, 1, 0, 0, 0, 0);  ex("prio_ex", 1, -1, 1, 1, -1); step();
        drive(0, 0, 0, 16, 1, 0, 0); step();
        drive(0, 0, 0, 16, 1, 0, 0); step();
        drive(0, 0, 0, 22, 1, 0, 0); step();
        drive(16, 22, 1, 0, 0, 0, 0); ex("prio_mem", 1, -1, 2, 1, -1); step();
        nops(3);

        // Asynchronous reset during a load-use hazard.
        drive(0, 0, 0, 5, 1, 0, 0);  step();
        drive(5, 0, 0, 8, 1, 1, 0);  step();
        drive(8, 0, 0, 11, 1, 0, 0);
        rst_i = 1'b1;
        ex("rst_async", 0, 0, 0, 0, 0); push("rst_async", 0, 4, 0); step();
        ex("rst_hold", 0, 0, 0, 0, 0); step();
        rst_i = 1'b0;
        ex("rst_release", 0, 0, -1, -1, -1); ex("rst_release", 1, -1, 0, 0, 0); step();
        nops(3);

        // Five forced stalls: 16-bit counter reaches 5, 2-bit counter saturates at 3.
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 8, 1, 1, 0); step();
            drive(8, 0, 0, 9, 1, 0, 0);
            ex("sat", 0, 1, -1, -1, -1);
            ex("sat", 1, -1, -1, -1, k + 1);
            push("sat", 1, 4, (k + 1 > 3) ? 3 : k + 1);
            step();
        end
        nops(2);
        ex("sat_end", 0, 0, -1, -1, 5);
        push("sat_end", 0, 4, 3);
        step();

        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        if (sb.size() != 0) begin
            drain_expired = 1'b1;
            step();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
